// File: rtl/prog_timer.sv
// Programmable up-counting timer: prescaler, period compare, periodic/one-shot modes,
// single-cycle expire pulse and a sticky interrupt flag.
module prog_timer #(
   parameter int WIDTH = 32,
   parameter int PRE_W = 16
) (
   input  logic             clk_clock,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             oneshot,
   input  logic [WIDTH-1:0] period,
   input  logic [PRE_W-1:0] prescale,
   input  logic             irq_clr,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             expire,
   output logic             irq
);

   typedef enum logic {ST_IDLE, ST_RUN} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [PRE_W-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] per_sh_q, per_sh_d;
   logic [PRE_W-1:0] pre_sh_q, pre_sh_d;
   logic             mode_sh_q, mode_sh_d;
   logic             expire_q, expire_d;
   logic             irq_q, irq_d;
   logic             tick;
   logic             term_ev;

   // A pending start or stop pre-empts any tick in the same cycle.
   assign tick    = (state_q == ST_RUN) && (pc_q == pre_sh_q);
   assign term_ev = tick && (count_q == per_sh_q) && !start && !stop;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      pc_d      = pc_q;
      per_sh_d  = per_sh_q;
      pre_sh_d  = pre_sh_q;
      mode_sh_d = mode_sh_q;
      expire_d  = 1'b0;
      irq_d     = irq_q;

      if (stop) begin
         state_d = ST_IDLE;
      end else if (start) begin
         per_sh_d  = period;
         pre_sh_d  = prescale;
         mode_sh_d = oneshot;
         count_d   = '0;
         pc_d      = '0;
         state_d   = ST_RUN;
      end else if (state_q == ST_RUN) begin
         pc_d = tick ? '0 : pc_q + PRE_W'(1);
         if (term_ev) begin
            count_d  = '0;
            expire_d = 1'b1;
            if (mode_sh_q) state_d = ST_IDLE;
         end else if (tick) begin
            count_d = count_q + WIDTH'(1);
         end
      end

      if (irq_clr) irq_d = 1'b0;
      if (term_ev) irq_d = 1'b1;
   end

   always_ff @(posedge clk_clock or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         pc_q      <= '0;
         per_sh_q  <= '0;
         pre_sh_q  <= '0;
         mode_sh_q <= 1'b0;
         expire_q  <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         pc_q      <= pc_d;
         per_sh_q  <= per_sh_d;
         pre_sh_q  <= pre_sh_d;
         mode_sh_q <= mode_sh_d;
         expire_q  <= expire_d;
         irq_q     <= irq_d;
      end
   end

   assign count   = count_q;
   assign running = (state_q == ST_RUN);
   assign expire  = expire_q;
   assign irq     = irq_q;

endmodule
